// File: rtl/efuse_seq_ctrl.sv
// eFuse program/read sequencer: drives SCLK/CSB/PGM and the power switch from a
// single clock, with all timing derived from a DIV-cycle tick prescaler.
module efuse_seq_ctrl #(
    parameter int NBITS   = 32,
    parameter int TCKHP_W = 4,
    parameter int DIV     = 5,
    parameter int T_PWR   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [TCKHP_W-1:0] tckhp,
    input  logic [NBITS-1:0]   prog,
    input  logic               dout,
    output logic               en,
    output logic               rampena,
    output logic               short,
    output logic               csb,
    output logic               pgm,
    output logic               sclk,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [NBITS-1:0]   rdata,
    output logic [2:0]         dbg_state
);
    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(NBITS + 1);
    localparam int PW = $clog2(T_PWR + 1);
    localparam int TW = (TCKHP_W > PW) ? TCKHP_W : PW;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PWR_UP = 3'd1,
        SETUP  = 3'd2,
        BIT_HI = 3'd3,
        BIT_LO = 3'd4,
        HOLD   = 3'd5,
        PWR_DN = 3'd6,
        DONE   = 3'd7
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [TW-1:0]    tcnt, tcnt_n, hp_q, hp_in;
    logic [IW-1:0]    idx, idx_n;
    logic [NBITS-1:0] prog_q, shadow;
    logic [1:0]       mode_q;
    logic             start_d, start_edge, tick, legal, accept, bad;
    logic             is_prog, prog_sel, sample, pgm_bit;
    logic             en_n, rampena_n, short_n, csb_n, pgm_n, sclk_n, busy_n, done_n;

    assign start_edge = start & ~start_d;
    assign tick       = (cnt == CW'(DIV - 1));
    assign legal      = (mode == 2'b01) || (mode == 2'b10);
    assign accept     = (state == IDLE) && start_edge && legal;
    assign bad        = (state == IDLE) && start_edge && !legal;
    assign is_prog    = (mode_q == 2'b01);
    // On the accept cycle the latched mode is stale, so look at the live input.
    assign prog_sel   = accept ? (mode == 2'b01) : is_prog;
    assign hp_in      = (tckhp == '0) ? TW'(1) : TW'(tckhp);
    assign sample     = (state == BIT_HI) && tick && (tcnt == hp_q - TW'(1));
    assign dbg_state  = state;

    always_comb begin
        state_n = state;
        tcnt_n  = tcnt;
        idx_n   = idx;
        pgm_bit = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = (mode == 2'b01) ? PWR_UP : SETUP;
                    tcnt_n  = '0;
                    idx_n   = '0;
                end
            end
            PWR_UP: begin
                if (tick) begin
                    if (tcnt == TW'(T_PWR - 1)) begin
                        state_n = SETUP;
                        tcnt_n  = '0;
                    end else begin
                        tcnt_n = tcnt + TW'(1);
                    end
                end
            end
            SETUP: begin
                if (tick) begin
                    state_n = BIT_HI;
                    tcnt_n  = '0;
                end
            end
            BIT_HI: begin
                if (tick) begin
                    if (tcnt == hp_q - TW'(1)) begin
                        state_n = BIT_LO;
                        tcnt_n  = '0;
                    end else begin
                        tcnt_n = tcnt + TW'(1);
                    end
                end
            end
            BIT_LO: begin
                if (tick) begin
                    idx_n   = idx + IW'(1);
                    state_n = (idx_n < IW'(NBITS)) ? BIT_HI : HOLD;
                end
            end
            HOLD: begin
                if (tick) state_n = is_prog ? PWR_DN : DONE;
            end
            PWR_DN: begin
                if (tick) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        for (int b = 0; b < NBITS; b++) begin
            if (idx_n == IW'(b)) pgm_bit = prog_q[b];
        end

        // Outputs are registered from the next state so they move one cycle after the tick.
        en_n      = prog_sel && (state_n inside {PWR_UP, SETUP, BIT_HI, BIT_LO, HOLD});
        rampena_n = prog_sel && (state_n inside {SETUP, BIT_HI, BIT_LO, HOLD});
        short_n   = !en_n;
        csb_n     = !(state_n inside {SETUP, BIT_HI, BIT_LO});
        sclk_n    = (state_n == BIT_HI);
        pgm_n     = sclk_n && is_prog && pgm_bit;
        busy_n    = (state_n != IDLE) && (state_n != DONE);
        done_n    = (state_n == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            tcnt    <= '0;
            idx     <= '0;
            prog_q  <= '0;
            mode_q  <= '0;
            hp_q    <= TW'(1);
            shadow  <= '0;
            start_d <= 1'b1;
            en      <= 1'b0;
            rampena <= 1'b0;
            short   <= 1'b1;
            csb     <= 1'b1;
            pgm     <= 1'b0;
            sclk    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            state   <= state_n;
            tcnt    <= tcnt_n;
            idx     <= idx_n;
            start_d <= start;
            if (accept || tick) cnt <= '0;
            else                cnt <= cnt + CW'(1);
            if (accept) begin
                prog_q <= prog;
                mode_q <= mode;
                hp_q   <= hp_in;
            end
            if (sample) begin
                for (int b = 0; b < NBITS; b++) begin
                    if (idx == IW'(b)) shadow[b] <= dout;
                end
            end
            if ((state == HOLD) && tick && !is_prog) rdata <= shadow;
            en      <= en_n;
            rampena <= rampena_n;
            short   <= short_n;
            csb     <= csb_n;
            pgm     <= pgm_n;
            sclk    <= sclk_n;
            busy    <= busy_n;
            done    <= done_n;
            err     <= bad;
        end
    end
endmodule

// File: tb/tb_efuse_seq_ctrl.sv
// Bench for efuse_seq_ctrl: a timeline model (tick index -> phase of the
// operation) is compared against every output on every cycle, plus directed checks.
module tb_efuse_seq_ctrl;
    localparam int NB    = 32;
    localparam int TW    = 4;
    localparam int DIV   = 5;
    localparam int T_PWR = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic [TW-1:0] tckhp;
    logic [NB-1:0] prog;
    logic          dout = 1'b0;
    logic          en, rampena, short, csb, pgm, sclk, busy, done, err;
    logic [NB-1:0] rdata;
    logic [2:0]    dbg_state;

    efuse_seq_ctrl #(.NBITS(NB), .TCKHP_W(TW), .DIV(DIV), .T_PWR(T_PWR)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .tckhp(tckhp),
        .prog(prog), .dout(dout), .en(en), .rampena(rampena), .short(short),
        .csb(csb), .pgm(pgm), .sclk(sclk), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: phase 0 idle, 1 running (m_k cycles since busy rose), 2 done cycle.
    int            m_phase = 0;
    int            m_k = 0;
    bit            m_prog_mode = 1'b0;
    int            m_h = 1;
    logic [NB-1:0] m_prog = '0;
    logic [NB-1:0] m_shadow = '0;
    logic [NB-1:0] m_rdata = '0;
    bit            m_err = 1'b0;
    bit            m_start_prev = 1'b1;
    bit            m_edge;
    int            b1, b2;

    function automatic int total_ticks();
        return (m_prog_mode ? T_PWR + 3 : 2) + NB * (m_h + 1);
    endfunction

    // 0 power-up, 1 setup, 2 sclk high, 3 sclk low, 4 hold, 5 power-down; b = bit index
    function automatic int seg_of(input int k, output int b);
        int j;
        j = k / DIV;
        b = 0;
        if (m_prog_mode) begin
            if (j < T_PWR) return 0;
            j = j - T_PWR;
        end
        if (j == 0) return 1;
        if (j <= NB * (m_h + 1)) begin
            b = (j - 1) / (m_h + 1);
            return (((j - 1) % (m_h + 1)) < m_h) ? 2 : 3;
        end
        if (j == NB * (m_h + 1) + 1) return 4;
        return 5;
    endfunction

    function automatic logic [8:0] exp_ctl();
        int sg, b;
        logic pw, rp, cs, sc, pg;
        pw = 1'b0; rp = 1'b0; cs = 1'b1; sc = 1'b0; pg = 1'b0; b = 0;
        if (m_phase == 1) begin
            sg = seg_of(m_k, b);
            pw = m_prog_mode && (sg <= 4);
            rp = m_prog_mode && (sg >= 1) && (sg <= 4);
            cs = !((sg >= 1) && (sg <= 3));
            sc = (sg == 2);
            pg = sc && m_prog_mode && m_prog[b];
        end
        return {pw, rp, !pw, cs, pg, sc, m_phase == 1, m_phase == 2, m_err};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_k = 0; m_err = 1'b0; m_rdata = '0; m_shadow = '0;
            m_start_prev = 1'b1;
        end else begin
            m_edge = start && !m_start_prev;
            m_start_prev = start;
            m_err = 1'b0;
            case (m_phase)
                0: if (m_edge) begin
                    if (mode == 2'b01 || mode == 2'b10) begin
                        m_phase = 1; m_k = 0; m_prog_mode = (mode == 2'b01);
                        m_h = (tckhp == 0) ? 1 : int'(tckhp); m_prog = prog;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                1: begin
                    if (!m_prog_mode && seg_of(m_k, b1) == 2 && seg_of(m_k + 1, b2) == 3)
                        m_shadow[b1] = dout;
                    m_k++;
                    if (m_k == DIV * total_ticks()) begin
                        m_phase = 2;
                        if (!m_prog_mode) m_rdata = m_shadow;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Event monitor used by the directed checks.
    int sclk_rises, pgm_pulses, pgm_rises, en_rises, busy_rises, done_cnt, err_cnt;
    int hi_run, hi_min, hi_max, en_cyc, ramp_cyc, busy_cyc, lat;
    logic sclk_p = 0, pgm_p = 0, en_p = 0, ramp_p = 0, busy_p = 0;
    bit dout_pat_mode = 1'b0;
    logic [NB-1:0] rd_pat = '0;

    task automatic clear_mon();
        sclk_rises = 0; pgm_pulses = 0; pgm_rises = 0; en_rises = 0; busy_rises = 0;
        done_cnt = 0; err_cnt = 0; hi_run = 0; hi_min = 100000; hi_max = 0;
        en_cyc = 0; ramp_cyc = 0; busy_cyc = 0; lat = 0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            check("ctl", {en, rampena, short, csb, pgm, sclk, busy, done, err}, exp_ctl());
            check("rdata", rdata, m_rdata);
        end
        if (sclk && !sclk_p) begin
            sclk_rises++; hi_run = 0;
            if (pgm) pgm_pulses++;
        end
        if (sclk) hi_run++;
        if (!sclk && sclk_p) begin
            if (hi_run < hi_min) hi_min = hi_run;
            if (hi_run > hi_max) hi_max = hi_run;
        end
        if (pgm && !pgm_p) pgm_rises++;
        if (en && !en_p) begin en_rises++; en_cyc = cyc; end
        if (rampena && !ramp_p) ramp_cyc = cyc;
        if (busy && !busy_p) begin busy_rises++; busy_cyc = cyc; end
        if (done) begin done_cnt++; lat = cyc - busy_cyc; end
        if (err) err_cnt++;
        if (dout_pat_mode) begin
            if (sclk && sclk_rises >= 1) dout = rd_pat[sclk_rises - 1];
        end else begin
            dout = 1'($urandom_range(0, 1));
        end
        sclk_p = sclk; pgm_p = pgm; en_p = en; ramp_p = rampena; busy_p = busy;
    end

    task automatic launch(input logic [1:0] md, input int hp, input logic [NB-1:0] pd);
        @(posedge clk); #1;
        mode = md; tckhp = TW'(hp); prog = pd; start = 1'b0;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n, d0;
        n = 0; d0 = done_cnt;
        while (done_cnt == d0 && n < 4000) begin
            @(posedge clk); n++;
        end
        check(name, done_cnt != d0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int n, b0, md, hp;
        logic [NB-1:0] pd;
        rst = 1'b1; start = 1'b0; mode = 2'b00; tckhp = '0; prog = '0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", {en, rampena, short, csb, pgm, sclk, busy, done, err}, 9'b001100000);
        check("reset_rdata", rdata, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Program 0xA5A50001, tckhp=4
        clear_mon();
        launch(2'b01, 4, 32'hA5A50001);
        wait_done("prog_done_seen");
        check("prog_latency", lat, 835);
        check("prog_pulses", sclk_rises, 32);
        check("prog_pgm_pulses", pgm_pulses, 9);
        check("prog_hi_min", hi_min, 20);
        check("prog_hi_max", hi_max, 20);
        check("prog_ramp_delay", ramp_cyc - en_cyc, 20);
        check("prog_rdata_kept", rdata, 0);

        // Read with dout following 0x12345678 bit by bit
        clear_mon();
        rd_pat = 32'h12345678; dout_pat_mode = 1'b1;
        launch(2'b10, 4, 32'hFFFFFFFF);
        wait_done("read_done_seen");
        dout_pat_mode = 1'b0;
        check("read_rdata", rdata, 32'h12345678);
        check("read_latency", lat, 810);
        check("read_no_en", en_rises, 0);
        check("read_no_pgm", pgm_rises, 0);

        // tckhp=0 behaves as 1
        clear_mon();
        launch(2'b01, 0, 32'h0000FFFF);
        wait_done("hp0_done_seen");
        check("hp0_latency", lat, 355);
        check("hp0_hi_width", hi_max, 5);
        check("hp0_rdata_kept", rdata, 32'h12345678);

        // Illegal mode, then a normal program operation
        clear_mon();
        launch(2'b11, 4, 32'h1);
        repeat (5) @(posedge clk);
        check("illegal_err_pulses", err_cnt, 1);
        check("illegal_no_busy", busy_rises, 0);
        launch(2'b01, 2, 32'h80000001);
        wait_done("after_illegal_done_seen");
        check("after_illegal_done_cnt", done_cnt, 1);

        // Start re-toggled while busy
        clear_mon();
        launch(2'b01, 4, 32'h5A5A5A5A);
        for (int t = 0; t < 3; t++) begin
            repeat (50) @(posedge clk);
            #1; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
        end
        wait_done("retoggle_done_seen");
        repeat (20) @(posedge clk);
        check("retoggle_pulses", sclk_rises, 32);
        check("retoggle_done_cnt", done_cnt, 1);
        check("retoggle_busy_rises", busy_rises, 1);

        // Asynchronous reset during BIT_HI of bit 10
        clear_mon();
        launch(2'b01, 4, 32'hFFFFFFFF);
        n = 0;
        while (sclk_rises < 11 && n < 2000) begin
            @(posedge clk); n++;
        end
        check("rst_reach_bit10", sclk_rises >= 11, 1);
        @(posedge clk); #2;
        check("pre_rst_sclk", sclk, 1);
        rst = 1'b1;
        #1;
        check("rst_async", {en, rampena, short, csb, pgm, sclk, busy, done}, 8'b00110000);
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        b0 = busy_rises;
        repeat (10) @(posedge clk);
        #1;
        check("start_held_no_op", busy_rises, b0);
        check("rst_no_done", done_cnt, 0);
        start = 1'b0;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done("post_rst_done_seen");
        check("post_rst_done_cnt", done_cnt, 1);

        // Randomized operations against the model
        for (int r = 0; r < 8; r++) begin
            md = $urandom_range(0, 3);
            hp = $urandom_range(0, 6);
            pd = $urandom;
            launch(2'(md), hp, pd);
            if (md == 1 || md == 2) wait_done("rand_done_seen");
            else repeat (4) @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
